// File: rtl/idma_axi_write.sv
// Purpose : AXI write-side shaper for the iDMA backend; turns per-byte buffer data into W beats.
// Latency : combinational W/AW/B paths; state only tracks beat position and outstanding B count.
// Backpres: W valid waits for all masked bytes plus outstanding room; bytes pop only on W handshake.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   w_dp_*                        burst descriptor in (offset/tailer/len), ready pulses on last beat
//   w_dp_rsp_*                    burst response to backend (B pass-through)
//   aw_req_i/aw_valid_i/aw_ready_o  AW meta request, passed straight to axi_aw_*
//   axi_w_*, axi_b_*              AXI W and B channels
//   buffer_out_*                  per-byte read side of the data buffer
//   busy_o                        burst in flight or B responses outstanding
module idma_axi_write #(
  parameter int StrbWidth      = 16,
  parameter int MaxOutstanding = 4,
  parameter int AwWidth        = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  // write datapath request
  input  logic                       w_dp_valid_i,
  output logic                       w_dp_ready_o,
  input  logic [$clog2(StrbWidth)-1:0] w_dp_offset_i,
  input  logic [$clog2(StrbWidth)-1:0] w_dp_tailer_i,
  input  logic [7:0]                 w_dp_len_i,
  // burst response
  output logic                       w_dp_rsp_valid_o,
  input  logic                       w_dp_rsp_ready_i,
  output logic [1:0]                 w_dp_rsp_resp_o,
  // AW meta request
  input  logic [AwWidth-1:0]         aw_req_i,
  input  logic                       aw_valid_i,
  output logic                       aw_ready_o,
  // AXI AW
  output logic [AwWidth-1:0]         axi_aw_o,
  output logic                       axi_aw_valid_o,
  input  logic                       axi_aw_ready_i,
  // AXI W
  output logic [8*StrbWidth-1:0]     axi_w_data_o,
  output logic [StrbWidth-1:0]       axi_w_strb_o,
  output logic                       axi_w_last_o,
  output logic                       axi_w_valid_o,
  input  logic                       axi_w_ready_i,
  // AXI B
  input  logic [1:0]                 axi_b_resp_i,
  input  logic                       axi_b_valid_i,
  output logic                       axi_b_ready_o,
  // buffer read side
  input  logic [8*StrbWidth-1:0]     buffer_out_i,
  input  logic [StrbWidth-1:0]       buffer_out_valid_i,
  output logic [StrbWidth-1:0]       buffer_out_ready_o,
  output logic                       busy_o
);

  localparam int OffW  = $clog2(StrbWidth);
  localparam int PendW = $clog2(MaxOutstanding + 1);
  localparam logic [OffW:0]    StrbCnt = StrbWidth[OffW:0];
  localparam logic [PendW-1:0] MaxPend = PendW'(MaxOutstanding);

  logic [7:0]           beat_cnt_q;
  logic                 first_q;
  logic [PendW-1:0]     pending_q;

  logic [StrbWidth-1:0] first_mask, last_mask, mask;
  logic [OffW:0]        tail_shift;
  logic                 is_last, beat_ready, pend_full;
  logic                 w_hs, last_hs, b_hs;

  // AW and B are pure pass-through; only W needs shaping.
  assign axi_aw_o         = aw_req_i;
  assign axi_aw_valid_o   = aw_valid_i;
  assign aw_ready_o       = axi_aw_ready_i;

  assign w_dp_rsp_valid_o = axi_b_valid_i;
  assign w_dp_rsp_resp_o  = axi_b_resp_i;
  assign axi_b_ready_o    = w_dp_rsp_ready_i;

  // Byte-enable masks: first beat drops leading bytes, last beat keeps only tailer bytes.
  assign tail_shift = StrbCnt - {1'b0, w_dp_tailer_i};
  assign first_mask = {StrbWidth{1'b1}} << w_dp_offset_i;
  assign last_mask  = (w_dp_tailer_i == '0) ? {StrbWidth{1'b1}}
                                            : ({StrbWidth{1'b1}} >> tail_shift);

  assign is_last = (beat_cnt_q == w_dp_len_i);

  always_comb begin
    mask = {StrbWidth{1'b1}};
    if (first_q) mask = mask & first_mask;
    if (is_last) mask = mask & last_mask;
  end

  // A beat may only go out once every byte it will strobe is present in the buffer.
  assign beat_ready = &(buffer_out_valid_i | ~mask);
  // Room check applies only when opening a new burst; a started burst always finishes.
  assign pend_full  = (pending_q == MaxPend);

  // rst_ni gating keeps the W/pop handshake dead while reset is asserted,
  // so a burst interrupted by reset never pops further buffer bytes.
  assign axi_w_valid_o = rst_ni & w_dp_valid_i & beat_ready & ~(first_q & pend_full);
  assign axi_w_strb_o  = mask;
  assign axi_w_data_o  = buffer_out_i;
  assign axi_w_last_o  = is_last;

  assign w_hs    = axi_w_valid_o & axi_w_ready_i;
  assign last_hs = w_hs & is_last;
  assign b_hs    = axi_b_valid_i & w_dp_rsp_ready_i;

  assign buffer_out_ready_o = w_hs ? mask : '0;
  assign w_dp_ready_o       = last_hs;
  assign busy_o             = ~first_q | (pending_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
      first_q    <= 1'b1;
      pending_q  <= '0;
    end else begin
      if (w_hs) begin
        beat_cnt_q <= last_hs ? 8'd0 : beat_cnt_q + 8'd1;
        first_q    <= last_hs;
      end
      // Simultaneous completion and response cancel out.
      if (last_hs && !b_hs) begin
        pending_q <= pending_q + 1'b1;
      end else if (!last_hs && b_hs && pending_q != '0) begin
        pending_q <= pending_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_idma_axi_write.sv
module tb_idma_axi_write;

  localparam int SW = 16;
  localparam int MO = 4;
  localparam int AW = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          w_dp_valid_i, w_dp_ready_o;
  logic [3:0]    w_dp_offset_i, w_dp_tailer_i;
  logic [7:0]    w_dp_len_i;
  logic          w_dp_rsp_valid_o, w_dp_rsp_ready_i;
  logic [1:0]    w_dp_rsp_resp_o;
  logic [AW-1:0] aw_req_i, axi_aw_o;
  logic          aw_valid_i, aw_ready_o, axi_aw_valid_o, axi_aw_ready_i;
  logic [8*SW-1:0] axi_w_data_o, buffer_out_i;
  logic [SW-1:0] axi_w_strb_o, buffer_out_valid_i, buffer_out_ready_o;
  logic          axi_w_last_o, axi_w_valid_o, axi_w_ready_i;
  logic [1:0]    axi_b_resp_i;
  logic          axi_b_valid_i, axi_b_ready_o, busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  idma_axi_write #(.StrbWidth(SW), .MaxOutstanding(MO), .AwWidth(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .w_dp_valid_i(w_dp_valid_i), .w_dp_ready_o(w_dp_ready_o),
    .w_dp_offset_i(w_dp_offset_i), .w_dp_tailer_i(w_dp_tailer_i), .w_dp_len_i(w_dp_len_i),
    .w_dp_rsp_valid_o(w_dp_rsp_valid_o), .w_dp_rsp_ready_i(w_dp_rsp_ready_i),
    .w_dp_rsp_resp_o(w_dp_rsp_resp_o),
    .aw_req_i(aw_req_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .axi_aw_o(axi_aw_o), .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i),
    .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o),
    .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
    .axi_b_resp_i(axi_b_resp_i), .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o),
    .buffer_out_i(buffer_out_i), .buffer_out_valid_i(buffer_out_valid_i),
    .buffer_out_ready_o(buffer_out_ready_o), .busy_o(busy_o)
  );

  // Return B ok responses until busy drops, bounded.
  task automatic drain_b(input string tag);
    bit done = 0;
    axi_b_valid_i = 1'b1; axi_b_resp_i = 2'b00; w_dp_rsp_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i); #1;
      if (!busy_o) begin done = 1; break; end
    end
    axi_b_valid_i = 1'b0; w_dp_rsp_ready_i = 1'b0;
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL %s_drain: busy_o still %b after 20 B cycles, want 0", tag, busy_o); end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    w_dp_valid_i = 1'b1; buffer_out_valid_i = '1; axi_w_ready_i = 1'b1;
    w_dp_offset_i = 4'd0; w_dp_tailer_i = 4'd0; w_dp_len_i = 8'd0;
    repeat (2) @(negedge clk_i); #1;
    n_cmp++; if (axi_w_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_wvalid: got %b want 0", axi_w_valid_o); end
    n_cmp++; if (w_dp_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_dpready: got %b want 0", w_dp_ready_o); end
    n_cmp++; if (buffer_out_ready_o !== 16'h0) begin n_err++; $display("FAIL rst_bufrdy: got %h want 0000", buffer_out_ready_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    @(negedge clk_i);
    w_dp_valid_i = 1'b0; rst_ni = 1'b1; #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_passthrough();
    aw_req_i = 64'hDEAD_BEEF_0123_4567; aw_valid_i = 1'b1; axi_aw_ready_i = 1'b0;
    axi_b_valid_i = 1'b1; axi_b_resp_i = 2'b11; w_dp_rsp_ready_i = 1'b0; #1;
    n_cmp++; if (axi_aw_o !== 64'hDEAD_BEEF_0123_4567) begin n_err++; $display("FAIL aw_pass: got %h", axi_aw_o); end
    n_cmp++; if ({axi_aw_valid_o, aw_ready_o} !== 2'b10) begin n_err++; $display("FAIL aw_hs: got %b want 10", {axi_aw_valid_o, aw_ready_o}); end
    n_cmp++; if ({w_dp_rsp_valid_o, w_dp_rsp_resp_o, axi_b_ready_o} !== 4'b1110) begin n_err++; $display("FAIL b_pass: got %b want 1110", {w_dp_rsp_valid_o, w_dp_rsp_resp_o, axi_b_ready_o}); end
    aw_valid_i = 1'b0; axi_aw_ready_i = 1'b1; axi_b_valid_i = 1'b0; #1;
    n_cmp++; if ({axi_aw_valid_o, aw_ready_o} !== 2'b01) begin n_err++; $display("FAIL aw_hs2: got %b want 01", {axi_aw_valid_o, aw_ready_o}); end
    @(negedge clk_i);
  endtask

  task automatic test_multi_beat();
    logic [15:0]    exp_strb [3] = '{16'hFFF8, 16'hFFFF, 16'h001F};
    logic [127:0]   dat;
    w_dp_offset_i = 4'd3; w_dp_tailer_i = 4'd5; w_dp_len_i = 8'd2;
    buffer_out_valid_i = '1; axi_w_ready_i = 1'b1; w_dp_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dat = {4{32'hA500_0000 + 32'(k)}};
      buffer_out_i = dat; #1;
      n_cmp++; if (axi_w_valid_o !== 1'b1) begin n_err++; $display("FAIL mb_valid%0d: got %b want 1", k, axi_w_valid_o); end
      n_cmp++; if (axi_w_strb_o !== exp_strb[k]) begin n_err++; $display("FAIL mb_strb%0d: got %h want %h", k, axi_w_strb_o, exp_strb[k]); end
      n_cmp++; if (axi_w_last_o !== (k == 2)) begin n_err++; $display("FAIL mb_last%0d: got %b want %b", k, axi_w_last_o, k == 2); end
      n_cmp++; if (w_dp_ready_o !== (k == 2)) begin n_err++; $display("FAIL mb_dprdy%0d: got %b want %b", k, w_dp_ready_o, k == 2); end
      n_cmp++; if (buffer_out_ready_o !== exp_strb[k]) begin n_err++; $display("FAIL mb_bufrdy%0d: got %h want %h", k, buffer_out_ready_o, exp_strb[k]); end
      n_cmp++; if (axi_w_data_o !== dat) begin n_err++; $display("FAIL mb_data%0d: got %h want %h", k, axi_w_data_o, dat); end
      n_cmp++; if (busy_o !== (k != 0)) begin n_err++; $display("FAIL mb_busy%0d: got %b want %b", k, busy_o, k != 0); end
      @(negedge clk_i);
    end
    w_dp_valid_i = 1'b0; #1;
    n_cmp++; if ({busy_o, w_dp_ready_o} !== 2'b10) begin n_err++; $display("FAIL mb_after: busy,dprdy got %b want 10", {busy_o, w_dp_ready_o}); end
    drain_b("mb");
  endtask

  task automatic test_stall();
    w_dp_offset_i = 4'd1; w_dp_tailer_i = 4'd0; w_dp_len_i = 8'd1;
    buffer_out_i = {4{32'h1234_5678}}; axi_w_ready_i = 1'b0; w_dp_valid_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if ({axi_w_valid_o, axi_w_last_o, axi_w_strb_o} !== {2'b10, 16'hFFFE}) begin n_err++; $display("FAIL stall%0d: valid,last,strb got %b %b %h want 1 0 fffe", c, axi_w_valid_o, axi_w_last_o, axi_w_strb_o); end
      n_cmp++; if (buffer_out_ready_o !== 16'h0) begin n_err++; $display("FAIL stall_pop%0d: got %h want 0000", c, buffer_out_ready_o); end
      @(negedge clk_i);
    end
    axi_w_ready_i = 1'b1; #1;
    n_cmp++; if (buffer_out_ready_o !== 16'hFFFE) begin n_err++; $display("FAIL stall_rel: got %h want fffe", buffer_out_ready_o); end
    @(negedge clk_i); #1;
    n_cmp++; if ({axi_w_last_o, w_dp_ready_o, axi_w_strb_o} !== {2'b11, 16'hFFFF}) begin n_err++; $display("FAIL stall_last: got %b %b %h want 1 1 ffff", axi_w_last_o, w_dp_ready_o, axi_w_strb_o); end
    @(negedge clk_i);
    w_dp_valid_i = 1'b0;
    drain_b("stall");
  endtask

  task automatic test_single_beat();
    w_dp_offset_i = 4'd2; w_dp_tailer_i = 4'd6; w_dp_len_i = 8'd0;
    buffer_out_valid_i = '1; axi_w_ready_i = 1'b1; w_dp_valid_i = 1'b1; #1;
    n_cmp++; if (axi_w_strb_o !== 16'h003C) begin n_err++; $display("FAIL sb_strb: got %h want 003c", axi_w_strb_o); end
    n_cmp++; if ({axi_w_valid_o, axi_w_last_o, w_dp_ready_o} !== 3'b111) begin n_err++; $display("FAIL sb_ctl: got %b want 111", {axi_w_valid_o, axi_w_last_o, w_dp_ready_o}); end
    n_cmp++; if (buffer_out_ready_o !== 16'h003C) begin n_err++; $display("FAIL sb_bufrdy: got %h want 003c", buffer_out_ready_o); end
    @(negedge clk_i);
    w_dp_valid_i = 1'b0;
    drain_b("sb");
  endtask

  task automatic test_beat_ready();
    w_dp_offset_i = 4'd0; w_dp_tailer_i = 4'd0; w_dp_len_i = 8'd0;
    buffer_out_valid_i = 16'h7FFF; axi_w_ready_i = 1'b1; w_dp_valid_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if ({axi_w_valid_o, w_dp_ready_o, buffer_out_ready_o} !== 18'h0) begin n_err++; $display("FAIL br_wait%0d: valid,dprdy,bufrdy got %b %b %h want 0 0 0000", c, axi_w_valid_o, w_dp_ready_o, buffer_out_ready_o); end
      @(negedge clk_i);
    end
    buffer_out_valid_i = 16'hFFFF; #1;
    n_cmp++; if ({axi_w_valid_o, axi_w_strb_o, buffer_out_ready_o} !== {1'b1, 16'hFFFF, 16'hFFFF}) begin n_err++; $display("FAIL br_go: valid,strb,bufrdy got %b %h %h want 1 ffff ffff", axi_w_valid_o, axi_w_strb_o, buffer_out_ready_o); end
    @(negedge clk_i);
    w_dp_valid_i = 1'b0;
    drain_b("br");
  endtask

  task automatic test_outstanding();
    w_dp_offset_i = 4'd0; w_dp_tailer_i = 4'd0; w_dp_len_i = 8'd0;
    buffer_out_valid_i = '1; axi_w_ready_i = 1'b1; w_dp_valid_i = 1'b1;
    axi_b_valid_i = 1'b0; w_dp_rsp_ready_i = 1'b0;
    for (int i = 0; i < MO; i++) begin
      #1;
      n_cmp++; if (axi_w_valid_o !== 1'b1) begin n_err++; $display("FAIL os_issue%0d: got %b want 1", i, axi_w_valid_o); end
      @(negedge clk_i);
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if ({axi_w_valid_o, buffer_out_ready_o} !== 17'h0) begin n_err++; $display("FAIL os_block%0d: valid,bufrdy got %b %h want 0 0000", c, axi_w_valid_o, buffer_out_ready_o); end
      @(negedge clk_i);
    end
    axi_b_valid_i = 1'b1; axi_b_resp_i = 2'b10; w_dp_rsp_ready_i = 1'b1; #1;
    n_cmp++; if ({w_dp_rsp_valid_o, w_dp_rsp_resp_o, axi_b_ready_o} !== 4'b1101) begin n_err++; $display("FAIL os_bresp: got %b want 1101", {w_dp_rsp_valid_o, w_dp_rsp_resp_o, axi_b_ready_o}); end
    n_cmp++; if (axi_w_valid_o !== 1'b0) begin n_err++; $display("FAIL os_same: got %b want 0", axi_w_valid_o); end
    @(negedge clk_i);
    axi_b_valid_i = 1'b0; w_dp_rsp_ready_i = 1'b0; #1;
    n_cmp++; if (axi_w_valid_o !== 1'b1) begin n_err++; $display("FAIL os_fifth: got %b want 1", axi_w_valid_o); end
    @(negedge clk_i);
    w_dp_valid_i = 1'b0;
    drain_b("os");
  endtask

  task automatic test_simultaneous();
    w_dp_offset_i = 4'd0; w_dp_tailer_i = 4'd0; w_dp_len_i = 8'd0;
    buffer_out_valid_i = '1; axi_w_ready_i = 1'b1; w_dp_valid_i = 1'b1;
    repeat (2) @(negedge clk_i);
    w_dp_len_i = 8'd1;
    @(negedge clk_i);
    axi_b_valid_i = 1'b1; axi_b_resp_i = 2'b00; w_dp_rsp_ready_i = 1'b1; #1;
    n_cmp++; if ({axi_w_last_o, w_dp_ready_o, axi_b_ready_o} !== 3'b111) begin n_err++; $display("FAIL sim_both: got %b want 111", {axi_w_last_o, w_dp_ready_o, axi_b_ready_o}); end
    @(negedge clk_i);
    w_dp_valid_i = 1'b0; axi_b_valid_i = 1'b0; w_dp_rsp_ready_i = 1'b0;
    @(negedge clk_i);
    axi_b_valid_i = 1'b1; w_dp_rsp_ready_i = 1'b1;
    @(negedge clk_i);
    axi_b_valid_i = 1'b0; w_dp_rsp_ready_i = 1'b0; #1;
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL sim_pend1: busy got %b want 1", busy_o); end
    @(negedge clk_i);
    axi_b_valid_i = 1'b1; w_dp_rsp_ready_i = 1'b1;
    @(negedge clk_i);
    axi_b_valid_i = 1'b0; w_dp_rsp_ready_i = 1'b0; #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL sim_pend0: busy got %b want 0", busy_o); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    w_dp_offset_i = 4'd4; w_dp_tailer_i = 4'd0; w_dp_len_i = 8'd2;
    buffer_out_valid_i = '1; axi_w_ready_i = 1'b1; w_dp_valid_i = 1'b1;
    @(negedge clk_i); #1;
    n_cmp++; if ({busy_o, axi_w_strb_o} !== {1'b1, 16'hFFFF}) begin n_err++; $display("FAIL rm_mid: busy,strb got %b %h want 1 ffff", busy_o, axi_w_strb_o); end
    rst_ni = 1'b0; #1;
    n_cmp++; if ({axi_w_valid_o, w_dp_ready_o, busy_o, buffer_out_ready_o} !== 19'h0) begin n_err++; $display("FAIL rm_rst: valid,dprdy,busy,bufrdy got %b %b %b %h want 0", axi_w_valid_o, w_dp_ready_o, busy_o, buffer_out_ready_o); end
    @(negedge clk_i);
    axi_w_ready_i = 1'b0; rst_ni = 1'b1; #1;
    n_cmp++; if ({axi_w_strb_o, axi_w_last_o, buffer_out_ready_o} !== {16'hFFF0, 1'b0, 16'h0}) begin n_err++; $display("FAIL rm_restart: strb,last,bufrdy got %h %b %h want fff0 0 0000", axi_w_strb_o, axi_w_last_o, buffer_out_ready_o); end
    w_dp_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; w_dp_valid_i = 1'b0; w_dp_offset_i = '0; w_dp_tailer_i = '0; w_dp_len_i = '0;
    w_dp_rsp_ready_i = 1'b0; aw_req_i = '0; aw_valid_i = 1'b0; axi_aw_ready_i = 1'b0;
    axi_w_ready_i = 1'b0; axi_b_resp_i = 2'b00; axi_b_valid_i = 1'b0;
    buffer_out_i = '0; buffer_out_valid_i = '0;
    test_reset();
    test_passthrough();
    test_multi_beat();
    test_stall();
    test_single_beat();
    test_beat_ready();
    test_outstanding();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
